// File: rtl/perspective_divide_pkg.sv
// Shared definitions for the perspective-divide stage: FSM encoding,
// half-precision constants and a small normalisation helper.
package perspective_divide_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DIV_X = 3'd1,
        DIV_Y = 3'd2,
        DIV_Z = 3'd3,
        DIV_W = 3'd4,
        OUT   = 3'd5
    } pd_state_t;

    localparam logic [15:0] HALF_ONE  = 16'h3C00;
    localparam logic [15:0] HALF_SAT  = 16'h7FFF;
    localparam logic [15:0] HALF_QNAN = 16'h7E00;

    // Number of leading zeros of an 11-bit significand (11 when it is zero).
    function automatic logic [3:0] lead_zeros11(input logic [10:0] m);
        logic [3:0] lz;
        lz = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (m[i]) begin
                lz = 4'(10 - i);
            end
        end
        return lz;
    endfunction

endpackage

// File: rtl/perspective_divide_div.sv
// Combinational IEEE-754 half-precision divider. Subnormal operands are
// normalised, the quotient is rounded to nearest-even, results that overflow
// saturate to infinity and results below the normal range flush to zero;
// both of those, NaN/infinity operands and a zero divisor raise o_Exception.
module divhalfprecision
    import perspective_divide_pkg::*;
(
    input  logic [15:0] i_Dividend,
    input  logic [15:0] i_Divisor,
    output logic [15:0] o_Quotient,
    output logic        o_Exception
);

    logic               sign_s;
    logic [10:0]        raw_a_s, raw_b_s, mant_a_s, mant_b_s;
    logic [3:0]         lz_a_s, lz_b_s;
    logic signed [7:0]  exp_a_s, exp_b_s, exp_pre_s, exp_fin_s;
    logic [23:0]        num_s, den_s;
    logic [13:0]        q_s;
    logic [10:0]        rem_s;
    logic [9:0]         mant_pre_s, mant_fin_s;
    logic [10:0]        mant_rnd_s;
    logic               guard_s, sticky_s, round_up_s;

    assign sign_s = i_Dividend[15] ^ i_Divisor[15];

    // Unpack both operands and shift subnormal significands up to a leading one.
    always_comb begin
        raw_a_s  = (i_Dividend[14:10] == 5'd0) ? {1'b0, i_Dividend[9:0]} : {1'b1, i_Dividend[9:0]};
        raw_b_s  = (i_Divisor[14:10]  == 5'd0) ? {1'b0, i_Divisor[9:0]}  : {1'b1, i_Divisor[9:0]};
        lz_a_s   = lead_zeros11(raw_a_s);
        lz_b_s   = lead_zeros11(raw_b_s);
        mant_a_s = raw_a_s << lz_a_s;
        mant_b_s = raw_b_s << lz_b_s;
        exp_a_s  = ((i_Dividend[14:10] == 5'd0) ? 8'sd1 : 8'(i_Dividend[14:10])) - 8'(lz_a_s);
        exp_b_s  = ((i_Divisor[14:10]  == 5'd0) ? 8'sd1 : 8'(i_Divisor[14:10]))  - 8'(lz_b_s);
    end

    // Significand ratio lies in (0.5, 2), so 13 fraction bits leave guard and sticky room.
    always_comb begin
        num_s = {mant_a_s, 13'd0};
        den_s = {13'd0, mant_b_s};
        if (mant_b_s != 11'd0) begin
            q_s   = 14'(num_s / den_s);
            rem_s = 11'(num_s % den_s);
        end else begin
            q_s   = 14'd0;
            rem_s = 11'd0;
        end
    end

    // Normalise the raw quotient, then round to nearest-even.
    always_comb begin
        if (q_s[13]) begin
            mant_pre_s = q_s[12:3];
            guard_s    = q_s[2];
            sticky_s   = (q_s[1:0] != 2'd0) || (rem_s != 11'd0);
            exp_pre_s  = exp_a_s - exp_b_s + 8'sd15;
        end else begin
            mant_pre_s = q_s[11:2];
            guard_s    = q_s[1];
            sticky_s   = q_s[0] || (rem_s != 11'd0);
            exp_pre_s  = exp_a_s - exp_b_s + 8'sd14;
        end
        round_up_s = guard_s & (sticky_s | mant_pre_s[0]);
        mant_rnd_s = {1'b0, mant_pre_s} + {10'd0, round_up_s};
        if (mant_rnd_s[10]) begin
            mant_fin_s = 10'd0;
            exp_fin_s  = exp_pre_s + 8'sd1;
        end else begin
            mant_fin_s = mant_rnd_s[9:0];
            exp_fin_s  = exp_pre_s;
        end
    end

    // Pick the final encoding; special operands take priority over arithmetic.
    always_comb begin
        if ((i_Dividend[14:10] == 5'h1F) || (i_Divisor[14:10] == 5'h1F)) begin
            o_Quotient  = HALF_QNAN;
            o_Exception = 1'b1;
        end else if (i_Divisor[14:0] == 15'd0) begin
            o_Quotient  = {sign_s, 5'h1F, 10'd0};
            o_Exception = 1'b1;
        end else if (i_Dividend[14:0] == 15'd0) begin
            o_Quotient  = {sign_s, 15'd0};
            o_Exception = 1'b0;
        end else if (exp_fin_s >= 8'sd31) begin
            o_Quotient  = {sign_s, 5'h1F, 10'd0};
            o_Exception = 1'b1;
        end else if (exp_fin_s <= 8'sd0) begin
            o_Quotient  = {sign_s, 15'd0};
            o_Exception = 1'b1;
        end else begin
            o_Quotient  = {sign_s, exp_fin_s[4:0], mant_fin_s};
            o_Exception = 1'b0;
        end
    end

endmodule

// File: rtl/perspective_divide.sv
// Perspective-divide stage: accepts one clip-space vertex, reuses a single
// half-precision divider over four cycles for x/w, y/w, z/w and 1/w, then
// holds the normalised vertex until downstream takes it.
module perspective_divide
    import perspective_divide_pkg::*;
#(
    parameter logic [15:0] ONE_HALF  = HALF_ONE,
    parameter logic [15:0] SAT_VALUE = HALF_SAT
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Valid,
    output logic        o_Ready,
    input  logic [15:0] i_X,
    input  logic [15:0] i_Y,
    input  logic [15:0] i_Z,
    input  logic [15:0] i_W,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic [15:0] o_X,
    output logic [15:0] o_Y,
    output logic [15:0] o_Z,
    output logic [15:0] o_InvW,
    output logic        o_Exception
);

    pd_state_t   state_r;
    logic [15:0] x_r, y_r, z_r, w_r;
    logic [15:0] out_x_r, out_y_r, out_z_r, out_invw_r;
    logic        exc_r, ready_r, valid_r;
    logic [15:0] dividend_s, div_quot_s, cap_quot_s;
    logic        div_exc_s, cap_exc_s, w_zero_s;

    assign w_zero_s = (w_r[14:0] == 15'd0);

    // Operand mux: registered component selected by the current divide state.
    always_comb begin
        case (state_r)
            DIV_X:   dividend_s = x_r;
            DIV_Y:   dividend_s = y_r;
            DIV_Z:   dividend_s = z_r;
            DIV_W:   dividend_s = ONE_HALF;
            default: dividend_s = 16'h0000;
        endcase
    end

    divhalfprecision u_div (
        .i_Dividend (dividend_s),
        .i_Divisor  (w_r),
        .o_Quotient (div_quot_s),
        .o_Exception(div_exc_s)
    );

    // A zero divisor bypasses the divider result entirely and saturates.
    always_comb begin
        if (w_zero_s) begin
            cap_quot_s = SAT_VALUE;
            cap_exc_s  = 1'b1;
        end else begin
            cap_quot_s = div_quot_s;
            cap_exc_s  = div_exc_s;
        end
    end

    // Sequencer: accept, four divide passes, then hold the result until taken.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_r    <= IDLE;
            x_r        <= 16'h0000;
            y_r        <= 16'h0000;
            z_r        <= 16'h0000;
            w_r        <= 16'h0000;
            out_x_r    <= 16'h0000;
            out_y_r    <= 16'h0000;
            out_z_r    <= 16'h0000;
            out_invw_r <= 16'h0000;
            exc_r      <= 1'b0;
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_Valid && ready_r) begin
                        x_r     <= i_X;
                        y_r     <= i_Y;
                        z_r     <= i_Z;
                        w_r     <= i_W;
                        exc_r   <= 1'b0;
                        ready_r <= 1'b0;
                        state_r <= DIV_X;
                    end
                end
                DIV_X: begin
                    out_x_r <= cap_quot_s;
                    exc_r   <= exc_r | cap_exc_s;
                    state_r <= DIV_Y;
                end
                DIV_Y: begin
                    out_y_r <= cap_quot_s;
                    exc_r   <= exc_r | cap_exc_s;
                    state_r <= DIV_Z;
                end
                DIV_Z: begin
                    out_z_r <= cap_quot_s;
                    exc_r   <= exc_r | cap_exc_s;
                    state_r <= DIV_W;
                end
                DIV_W: begin
                    out_invw_r <= cap_quot_s;
                    exc_r      <= exc_r | cap_exc_s;
                    valid_r    <= 1'b1;
                    state_r    <= OUT;
                end
                OUT: begin
                    if (i_Ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_Ready     = ready_r;
    assign o_Valid     = valid_r;
    assign o_X         = out_x_r;
    assign o_Y         = out_y_r;
    assign o_Z         = out_z_r;
    assign o_InvW      = out_invw_r;
    assign o_Exception = exc_r;

endmodule

// File: tb/tb_perspective_divide.sv
// Directed, table-driven bench for perspective_divide.
module tb_perspective_divide;

    logic        i_Clock = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Valid = 1'b0;
    logic        o_Ready;
    logic [15:0] i_X = 16'h0000, i_Y = 16'h0000, i_Z = 16'h0000, i_W = 16'h0000;
    logic        o_Valid;
    logic        i_Ready = 1'b1;
    logic [15:0] o_X, o_Y, o_Z, o_InvW;
    logic        o_Exception;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] x, y, z, w;
        logic [15:0] ex, ey, ez, ew;
        logic        ee;
    } vec_t;

    vec_t vecs[8];

    perspective_divide dut (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_X        (i_X),
        .i_Y        (i_Y),
        .i_Z        (i_Z),
        .i_W        (i_W),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_X        (o_X),
        .o_Y        (o_Y),
        .o_Z        (o_Z),
        .o_InvW     (o_InvW),
        .o_Exception(o_Exception)
    );

    // Free-running clock.
    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic check_outs(input vec_t v, input string tag);
        chk({tag, ".x"},   {16'd0, o_X},    {16'd0, v.ex});
        chk({tag, ".y"},   {16'd0, o_Y},    {16'd0, v.ey});
        chk({tag, ".z"},   {16'd0, o_Z},    {16'd0, v.ez});
        chk({tag, ".invw"},{16'd0, o_InvW}, {16'd0, v.ew});
        chk({tag, ".exc"}, {31'd0, o_Exception}, {31'd0, v.ee});
    endtask

    // Counts edges from the accept edge (inclusive) until o_Valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_Valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic present(input vec_t v);
        i_X = v.x; i_Y = v.y; i_Z = v.z; i_W = v.w;
        i_Valid = 1'b1;
    endtask

    task automatic scramble();
        i_Valid = 1'b0;
        i_X = 16'hDEAD; i_Y = 16'hBEEF; i_Z = 16'h1234; i_W = 16'h0000;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        present(v);
        chk({tag, ".ready"}, {31'd0, o_Ready}, 32'd1);
        tick();
        scramble();
        wait_valid(lat);
        chk({tag, ".latency"}, lat, 32'd5);
        check_outs(v, tag);
        chk({tag, ".no_x"}, {31'd0, $isunknown({o_X, o_Y, o_Z, o_InvW, o_Exception})}, 32'd0);
        tick();
        chk({tag, ".valid_drop"}, {31'd0, o_Valid}, 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        //          x        y        z        w        o_X      o_Y      o_Z      o_InvW   exc
        vecs[0] = '{16'h4400, 16'h4000, 16'h0000, 16'h4000, 16'h4000, 16'h3C00, 16'h0000, 16'h3800, 1'b0};
        vecs[1] = '{16'h4000, 16'hBC00, 16'h3C00, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[2] = '{16'hC400, 16'h4000, 16'h3C00, 16'h4000, 16'hC000, 16'h3C00, 16'h3800, 16'h3800, 1'b0};
        vecs[3] = '{16'h4000, 16'h4000, 16'h4000, 16'hC000, 16'hBC00, 16'hBC00, 16'hBC00, 16'hB800, 1'b0};
        vecs[4] = '{16'h7BFF, 16'h3C00, 16'h0000, 16'h0400, 16'h7C00, 16'h7400, 16'h0000, 16'h7400, 1'b1};
        vecs[5] = '{16'h0400, 16'h7800, 16'h4000, 16'h7800, 16'h0000, 16'h3C00, 16'h0400, 16'h0000, 1'b1};
        vecs[6] = '{16'h4000, 16'h4200, 16'h4500, 16'h4200, 16'h3955, 16'h3C00, 16'h3EAB, 16'h3555, 1'b0};
        vecs[7] = '{16'h0200, 16'h3C00, 16'hC000, 16'h3800, 16'h0400, 16'h4000, 16'hC400, 16'h4000, 1'b0};

        // Reset state.
        tick(); tick();
        chk("rst.valid", {31'd0, o_Valid}, 32'd0);
        chk("rst.ready", {31'd0, o_Ready}, 32'd1);
        chk("rst.outs", {o_X, o_Y}, 32'd0);
        chk("rst.outs2", {o_Z, o_InvW}, 32'd0);
        chk("rst.exc", {31'd0, o_Exception}, 32'd0);
        i_Reset = 1'b0;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-pressure: hold OUT for 10 cycles while a second vertex waits.
        i_Ready = 1'b0;
        present(vecs[0]);
        tick();
        scramble();
        wait_valid(lat);
        chk("bp.latency", lat, 32'd5);
        present(vecs[2]);
        for (int c = 0; c < 10; c++) begin
            chk("bp.valid", {31'd0, o_Valid}, 32'd1);
            chk("bp.ready", {31'd0, o_Ready}, 32'd0);
            chk("bp.xy", {o_X, o_Y}, {vecs[0].ex, vecs[0].ey});
            chk("bp.zw", {o_Z, o_InvW}, {vecs[0].ez, vecs[0].ew});
            tick();
        end
        i_Ready = 1'b1;
        tick();
        chk("bp.post_ready", {31'd0, o_Ready}, 32'd1);
        chk("bp.post_valid", {31'd0, o_Valid}, 32'd0);
        chk("bp.hold_x", {16'd0, o_X}, {16'd0, vecs[0].ex});
        tick();
        scramble();
        chk("bp.accepted", {31'd0, o_Ready}, 32'd0);
        wait_valid(lat);
        chk("bp2.latency", lat, 32'd5);
        check_outs(vecs[2], "bp2");
        tick();

        // Reset during DIV_Y discards the vertex.
        present(vecs[3]);
        tick();
        scramble();
        tick();
        #2;
        i_Reset = 1'b1;
        #1;
        chk("mrst.outs", {o_X, o_Y}, 32'd0);
        chk("mrst.outs2", {o_Z, o_InvW}, 32'd0);
        chk("mrst.exc", {31'd0, o_Exception}, 32'd0);
        chk("mrst.valid", {31'd0, o_Valid}, 32'd0);
        chk("mrst.ready", {31'd0, o_Ready}, 32'd1);
        tick();
        i_Reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_Valid) seen++;
        end
        chk("mrst.no_valid", seen, 32'd0);
        chk("mrst.ready_after", {31'd0, o_Ready}, 32'd1);
        run_vec(vecs[0], "mrst.next");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
